freq_sweep_ctrl: RTL and testbench
==================================

Name: freq_sweep_ctrl

Overview:
- Drives the frequency-step input of the sig_gen NCO and consumes its cosine/sine output stream.
- Steps the NCO through a programmed list of frequencies for the CAF frequency-offset search. Each step is start + k*incr.
- For each step: waits a fixed settle time for the NCO pipeline, then forwards exactly DWELL samples downstream, tagged with step index and last-flag.

Parameters:
PHASE_BITS, 32, width of freq_step phase increment
N_BITS, 16, width of cosine/sine samples
IDX_BITS, 10, width of step count and step index
DWELL_BITS, 16, width of dwell sample counter
SETTLE_CYCLES, 4, clock cycles of sig_gen output discarded after each freq_step load (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  synchronous abort; returns to IDLE
freq_start  in  PHASE_BITS  first phase increment, sampled on accepted start
freq_incr  in  PHASE_BITS  per-step increment (two's complement), sampled on accepted start
num_steps  in  IDX_BITS  number of frequency steps, sampled on accepted start
dwell  in  DWELL_BITS  samples forwarded per step, sampled on start; 0 treated as 1
m_axis_freq_step_tvalid  out  1  freq_step load strobe to sig_gen
freq_step  out  PHASE_BITS  phase increment to sig_gen
m_axis_data_tready  out  1  ready to sig_gen data output
s_axis_data_tvalid  in  1  sig_gen sample valid
cosine  in  N_BITS  signed sig_gen cosine
sine  in  N_BITS  signed sig_gen sine
out_tvalid  out  1  forwarded sample valid
out_tready  in  1  downstream ready
out_cosine  out  N_BITS  registered cosine
out_sine  out  N_BITS  registered sine
out_step_idx  out  IDX_BITS  step index of forwarded sample
out_last  out  1  last sample of the current step
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a sweep completes normally

Behaviour:
- Reset: state=IDLE. All outputs 0, including freq_step, done, busy and out_tvalid.
- States: IDLE, LOAD, SETTLE, DWELL.
- IDLE:
  - On start, latch all inputs and set step_idx=0.
  - If num_steps==0: pulse done next cycle and stay in IDLE.
  - Otherwise: freq_step<=freq_start and go to LOAD.
- LOAD (exactly 1 cycle):
  - m_axis_freq_step_tvalid=1; freq_step stable.
  - Next state SETTLE with settle_cnt=0.
- SETTLE (SETTLE_CYCLES cycles):
  - m_axis_data_tready=1; accepted samples are discarded.
  - Go to DWELL when settle_cnt==SETTLE_CYCLES-1.
- DWELL:
  - m_axis_data_tready = !out_tvalid || out_tready.
  - Accepted sample (s_axis_data_tvalid && m_axis_data_tready) is registered to out_* next cycle with out_tvalid=1. out_last=1 when dwell_cnt==dwell-1.
  - out_tvalid clears on out_tready unless a new sample is loaded in the same cycle.
  - Output data is held stable while out_tvalid && !out_tready.
- Step completion, on acceptance of the last sample of a step:
  - If step_idx==num_steps-1: go to IDLE and pulse done when that last sample is accepted downstream. The output stage must drain before done.
  - Otherwise: step_idx+1, freq_step<=freq_step+freq_incr (wraps mod 2^PHASE_BITS), go to LOAD.
- Outside DWELL and SETTLE, m_axis_data_tready=0.
- start while busy is ignored. Sampled inputs are not re-read mid-sweep.
- abort has priority over all transitions:
  - Next cycle: IDLE, out_tvalid=0, m_axis_freq_step_tvalid=0, no done pulse.
  - freq_step retains its last value.
- start and abort asserted together in IDLE: abort wins and start is ignored.
- Asynchronous reset mid-sweep returns all state and outputs to reset values immediately.
- Latency: start at cycle 0 → LOAD strobe at cycle 1 → first sample can be accepted at cycle 2+SETTLE_CYCLES.
- busy stays high until done is pulsed.

Test Plan:
- Basic sweep: freq_start=0x1000_0000, freq_incr=0x0100_0000, num_steps=3, dwell=4, out_tready=1.
  - Three LOAD strobes with freq_step 0x1000_0000, 0x1100_0000, 0x1200_0000.
  - 12 outputs with step_idx 0,0,0,0,1…2; out_last on every 4th.
  - Single done pulse; busy low afterwards.
- Wrap and negative increment: freq_start=0x0000_0010, freq_incr=0xFFFF_FFF0, num_steps=3.
  - freq_step sequence 0x10, 0x0, 0xFFFF_FFF0.
- Backpressure: out_tready random 50%, dwell=8.
  - Output data matches input sample order with no drops or duplicates.
  - m_axis_data_tready low whenever out_tvalid && !out_tready.
- Settle discard: SETTLE_CYCLES=4, sig_gen samples tagged with a counter.
  - First forwarded sample is the one presented at cycle 6 after start.
  - No samples are forwarded during SETTLE.
- Boundaries:
  - num_steps=0 → done pulse one cycle after start, no LOAD strobe.
  - dwell=0 behaves as dwell=1.
  - start while busy → no effect.
- Abort and reset:
  - abort during DWELL of step 1 → IDLE next cycle, out_tvalid=0, no done.
  - rst_n low mid-sweep → all outputs 0 asynchronously.
  - A new start afterwards runs a clean sweep.

Source files
------------

// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_sweep_ctrl
// Brief    : Steps a sig_gen NCO through start + k*incr and forwards DWELL
//            post-settle samples per step, tagged with step index and last.
// Revision : 1.0
// ============================================================================
module freq_sweep_ctrl #(
    parameter int PHASE_BITS    = 32,
    parameter int N_BITS        = 16,
    parameter int IDX_BITS      = 10,
    parameter int DWELL_BITS    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PHASE_BITS-1:0] freq_start,
    input  logic [PHASE_BITS-1:0] freq_incr,
    input  logic [IDX_BITS-1:0]   num_steps,
    input  logic [DWELL_BITS-1:0] dwell,
    output logic                  m_axis_freq_step_tvalid,
    output logic [PHASE_BITS-1:0] freq_step,
    output logic                  m_axis_data_tready,
    input  logic                  s_axis_data_tvalid,
    input  logic [N_BITS-1:0]     cosine,
    input  logic [N_BITS-1:0]     sine,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [N_BITS-1:0]     out_cosine,
    output logic [N_BITS-1:0]     out_sine,
    output logic [IDX_BITS-1:0]   out_step_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_DWELL  = 2'd3
    } state_t;

    localparam int              C_SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [C_SC_W-1:0] C_SC_LAST = C_SC_W'(SETTLE_CYCLES - 1);

    state_t                  state_q;
    logic [PHASE_BITS-1:0]   freq_step_q;
    logic [PHASE_BITS-1:0]   incr_q;
    logic [IDX_BITS-1:0]     nsteps_q;
    logic [DWELL_BITS-1:0]   dwell_q;
    logic [IDX_BITS-1:0]     step_idx_q;
    logic [C_SC_W-1:0]       settle_cnt_q;
    logic [DWELL_BITS-1:0]   dwell_cnt_q;
    logic                    drain_q;
    logic                    fs_valid_q;
    logic                    out_tvalid_q;
    logic [N_BITS-1:0]       out_cos_q;
    logic [N_BITS-1:0]       out_sin_q;
    logic [IDX_BITS-1:0]     out_idx_q;
    logic                    out_last_q;
    logic                    done_q;

    logic w_data_ready;
    logic w_accept;
    logic w_last_in_step;
    logic w_last_step;

    // drain_q: final sample is in the output stage; stop accepting until it leaves
    assign w_data_ready   = (state_q == S_SETTLE) ||
                            ((state_q == S_DWELL) && !drain_q && (!out_tvalid_q || out_tready));
    assign w_accept       = s_axis_data_tvalid && w_data_ready;
    assign w_last_in_step = (dwell_cnt_q == dwell_q - DWELL_BITS'(1));
    assign w_last_step    = (step_idx_q == nsteps_q - IDX_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            freq_step_q  <= '0;
            incr_q       <= '0;
            nsteps_q     <= '0;
            dwell_q      <= '0;
            step_idx_q   <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            drain_q      <= 1'b0;
            fs_valid_q   <= 1'b0;
            out_tvalid_q <= 1'b0;
            out_cos_q    <= '0;
            out_sin_q    <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            fs_valid_q <= 1'b0;
            if (out_tready) begin
                out_tvalid_q <= 1'b0;
            end
            if (abort) begin
                state_q      <= S_IDLE;
                out_tvalid_q <= 1'b0;
                drain_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            incr_q      <= freq_incr;
                            nsteps_q    <= num_steps;
                            dwell_q     <= (dwell == '0) ? DWELL_BITS'(1) : dwell;
                            step_idx_q  <= '0;
                            dwell_cnt_q <= '0;
                            if (num_steps == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                freq_step_q <= freq_start;
                                fs_valid_q  <= 1'b1;
                                state_q     <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        settle_cnt_q <= '0;
                        state_q      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt_q == C_SC_LAST) begin
                            state_q <= S_DWELL;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + C_SC_W'(1);
                        end
                    end
                    S_DWELL: begin
                        if (drain_q) begin
                            if (out_tvalid_q && out_tready) begin
                                drain_q <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else if (w_accept) begin
                            out_tvalid_q <= 1'b1;
                            out_cos_q    <= cosine;
                            out_sin_q    <= sine;
                            out_idx_q    <= step_idx_q;
                            out_last_q   <= w_last_in_step;
                            if (w_last_in_step) begin
                                dwell_cnt_q <= '0;
                                if (w_last_step) begin
                                    drain_q <= 1'b1;
                                end else begin
                                    step_idx_q  <= step_idx_q + IDX_BITS'(1);
                                    freq_step_q <= freq_step_q + incr_q;
                                    fs_valid_q  <= 1'b1;
                                    state_q     <= S_LOAD;
                                end
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q + DWELL_BITS'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign m_axis_freq_step_tvalid = fs_valid_q;
    assign freq_step               = freq_step_q;
    assign m_axis_data_tready      = w_data_ready;
    assign out_tvalid              = out_tvalid_q;
    assign out_cosine              = out_cos_q;
    assign out_sine                = out_sin_q;
    assign out_step_idx            = out_idx_q;
    assign out_last                = out_last_q;
    assign busy                    = (state_q != S_IDLE);
    assign done                    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_sweep_ctrl
// Brief    : Scoreboard bench for freq_sweep_ctrl with an AXIS sample source
//            tagging samples by loaded frequency and index since load.
// Revision : 1.0
// ============================================================================
module tb_freq_sweep_ctrl;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] freq_start = '0;
    logic [31:0] freq_incr = '0;
    logic [9:0]  num_steps = '0;
    logic [15:0] dwell = '0;
    logic        s_axis_data_tvalid = 1'b1;
    logic        out_tready = 1'b1;
    logic [15:0] cosine, sine;
    logic        m_axis_freq_step_tvalid, m_axis_data_tready, out_tvalid, out_last, busy, done;
    logic [31:0] freq_step;
    logic [15:0] out_cosine, out_sine;
    logic [9:0]  out_step_idx;

    freq_sweep_ctrl #(
        .PHASE_BITS(32), .N_BITS(16), .IDX_BITS(10), .DWELL_BITS(16), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .freq_start(freq_start), .freq_incr(freq_incr), .num_steps(num_steps), .dwell(dwell),
        .m_axis_freq_step_tvalid(m_axis_freq_step_tvalid), .freq_step(freq_step),
        .m_axis_data_tready(m_axis_data_tready), .s_axis_data_tvalid(s_axis_data_tvalid),
        .cosine(cosine), .sine(sine), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_cosine(out_cosine), .out_sine(out_sine), .out_step_idx(out_step_idx),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sample source: cosine carries the loaded frequency tag, sine counts samples since the load
    logic [15:0] src_tag, src_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_tag <= '0;
            src_cnt <= '0;
        end else if (m_axis_freq_step_tvalid) begin
            src_tag <= freq_step[31:16];
            src_cnt <= '0;
        end else if (s_axis_data_tvalid && m_axis_data_tready) begin
            src_cnt <= src_cnt + 16'd1;
        end
    end
    assign cosine = src_tag;
    assign sine   = src_cnt;

    typedef struct packed {
        logic [15:0] c;
        logic [15:0] s;
        logic [9:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] load_q[$];
    int          done_exp = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          bp = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred, required none", nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples at the falling edge, pops expectations on each DUT event
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_freq_step_tvalid) begin
                if (load_q.size() == 0) fail("unexpected_load");
                else chk("freq_step", freq_step, load_q.pop_front());
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_cosine", out_cosine, e.c);
                    chk("out_sine", out_sine, e.s);
                    chk("out_step_idx", out_step_idx, e.idx);
                    chk("out_last", out_last, e.last);
                end
            end
            if (out_tvalid && !out_tready) chk("tready_during_stall", m_axis_data_tready, 0);
            if (!busy) chk("tready_when_idle", m_axis_data_tready, 0);
            if (done) begin
                if (done_exp == 0) fail("unexpected_done");
                else begin
                    done_exp--;
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_tready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic push_model(input logic [31:0] fs, input logic [31:0] fi,
                              input logic [9:0] ns, input logic [15:0] dw);
        int          d1;
        logic [31:0] f;
        d1 = (dw == 0) ? 1 : int'(dw);
        if (ns == 0) done_exp++;
        for (int k = 0; k < int'(ns); k++) begin
            f = fs + 32'(k) * fi;
            load_q.push_back(f);
            for (int j = 0; j < d1; j++)
                exp_q.push_back('{f[31:16], 16'(SETTLE + j), 10'(k), (j == d1 - 1)});
        end
        if (ns != 0) done_exp++;
    endtask

    task automatic issue_start(input logic [31:0] fs, input logic [31:0] fi,
                               input logic [9:0] ns, input logic [15:0] dw);
        start = 1'b1;
        freq_start = fs;
        freq_incr = fi;
        num_steps = ns;
        dwell = dw;
        push_model(fs, fi, ns, dw);
        tick;
        start = 1'b0;
        freq_start = $urandom;
        freq_incr = $urandom;
        num_steps = 10'($urandom);
        dwell = 16'($urandom);
    endtask

    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fi,
                             input logic [9:0] ns, input logic [15:0] dw, input int inject);
        int budget;
        bit seen;
        issue_start(fs, fi, ns, dw);
        if (ns == 0) begin
            chk("zero_steps_done", done, 1);
            chk("zero_steps_busy", busy, 0);
            chk("zero_steps_no_load", m_axis_freq_step_tvalid, 0);
            tick;
            chk("zero_steps_done_single", done, 0);
            return;
        end
        chk("load_strobe_latency", m_axis_freq_step_tvalid, 1);
        chk("busy_in_sweep", busy, 1);
        seen = 1'b0;
        budget = 100 + int'(ns) * (((dw == 0) ? 1 : int'(dw)) * 8 + 16);
        for (int c = 0; c < budget && !seen; c++) begin
            if (c == inject) start = 1'b1;
            tick;
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        if (!seen) fail("sweep_timeout_no_done");
        chk("busy_after_done", busy, 0);
        chk("outputs_left", exp_q.size(), 0);
        chk("loads_left", load_q.size(), 0);
        tick;
        chk("done_single_pulse", done, 0);
        chk("done_count", done_exp, 0);
    endtask

    initial begin
        int  n;
        bit  hit;
        repeat (2) tick;
        chk("rst_freq_step", freq_step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_fs_valid", m_axis_freq_step_tvalid, 0);
        chk("rst_data_tready", m_axis_data_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        run_sweep(32'h1000_0000, 32'h0100_0000, 10'd3, 16'd4, -1);
        run_sweep(32'h0000_0010, 32'hFFFF_FFF0, 10'd3, 16'd2, -1);
        bp = 1'b1;
        run_sweep(32'h3456_7890, 32'h0123_4567, 10'd3, 16'd8, -1);
        bp = 1'b0;
        run_sweep(32'h5555_0000, 32'h1111_1111, 10'd0, 16'd4, -1);
        run_sweep(32'h7000_0000, 32'h0200_0000, 10'd3, 16'd0, -1);
        run_sweep(32'h0800_0000, 32'h0040_0000, 10'd2, 16'd5, 5);

        // abort during the dwell of step 1
        issue_start(32'h2000_0000, 32'h0010_0000, 10'd3, 16'd6);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (out_tvalid && out_step_idx == 10'd1) hit = 1'b1;
            else tick;
        end
        if (!hit) fail("abort_wait_timeout");
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_tvalid", out_tvalid, 0);
        chk("abort_fs_valid", m_axis_freq_step_tvalid, 0);
        chk("abort_freq_step_held", freq_step, 32'h2010_0000);
        chk("abort_done", done, 0);
        exp_q.delete();
        load_q.delete();
        done_exp = 0;
        repeat (10) tick;

        // start and abort together in idle
        start = 1'b1;
        abort = 1'b1;
        num_steps = 10'd2;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_no_load", m_axis_freq_step_tvalid, 0);

        // asynchronous reset mid-sweep
        issue_start(32'h4000_0000, 32'h0300_0000, 10'd4, 16'd5);
        repeat (14) tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_freq_step", freq_step, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_tvalid", out_tvalid, 0);
        chk("arst_out_sine", out_sine, 0);
        chk("arst_out_idx", out_step_idx, 0);
        chk("arst_data_tready", m_axis_data_tready, 0);
        exp_q.delete();
        load_q.delete();
        done_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run_sweep(32'h0F00_0000, 32'h0001_0000, 10'd2, 16'd3, -1);

        bp = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(4, 1);
            run_sweep($urandom, $urandom, 10'(n), 16'($urandom_range(6, 0)), -1);
        end
        bp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
